// File: rtl/line_memory.sv
// ----------------------------------------------------------------------------
// line_memory
//   Fixed-latency line store of DEPTH 256-bit lines behind a single request
//   port. A request is accepted in IDLE. It is held in WAIT for LATENCY-1
//   further cycles. It completes on the edge that enters ACK. ack_o is high
//   for the single ACK cycle, which begins exactly LATENCY cycles after the
//   accepting edge.
//
//   Optional feature (define LINE_MEMORY_RANGE_CHECK_EN to enable):
//     Accesses whose address bits above the line index are nonzero still
//     complete at the normal time, but they raise err_o together with ack_o.
//     Their write is dropped, and a read returns an all-zero line.
//   Default build (macro undefined):
//     The upper address bits are ignored, so addresses wrap modulo DEPTH
//     lines, and err_o is constant 0.
//
//   Line storage has no reset. Reset only returns the control path to IDLE
//   and clears the registered outputs, which aborts any transaction in
//   flight without performing its write.
// ----------------------------------------------------------------------------
module line_memory #(
    parameter int unsigned LATENCY = 10,   // 1..255
    parameter int unsigned DEPTH   = 512   // power of two, >= 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         err_o
);

    localparam int unsigned IDX_LSB = 5;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(LATENCY + 1);

    // Wait cycles still to run after the accepting edge
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [AW-1:0]      idx_r;
    logic [255:0]       wdata_r;
    logic               write_r;
    logic               ack_r;
    logic [255:0]       data_r;

    logic [255:0]       mem_r [DEPTH];

    logic               access_s;
    logic               oob_s;
    logic [255:0]       rd_line_s;
    logic               unused_addr_s;

    // The byte offset (and, without range checking, the upper bits) are
    // intentionally ignored.
    assign unused_addr_s = ^addr_i;

    // The access happens on the WAIT edge on which the counter has already
    // reached zero. This is the same edge that moves the FSM into ACK.
    assign access_s = (state_r == WAIT) && (cnt_r == CNT_W'(0));

`ifdef LINE_MEMORY_RANGE_CHECK_EN
    logic oob_r;
    logic err_r;
    logic addr_oob_s;

    assign addr_oob_s = (addr_i >> (IDX_LSB + AW)) != 32'd0;
    assign oob_s      = oob_r;
    assign err_o      = err_r;

    // Latch the out-of-range status with the request, and flag it in the ack cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            oob_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if ((state_r == IDLE) && enable_i) begin
                oob_r <= addr_oob_s;
            end
            err_r <= access_s ? oob_r : 1'b0;
        end
    end
`else
    assign oob_s = 1'b0;
    assign err_o = 1'b0;
`endif

    // An out-of-range read returns zeros; otherwise it returns the latched line.
    assign rd_line_s = oob_s ? 256'd0 : mem_r[idx_r];

    assign ack_o  = ack_r;
    assign data_o = data_r;

    // Line storage: written only when a latched, in-range write completes; never reset.
    always_ff @(posedge clk_i) begin
        if (access_s && write_r && !oob_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    // Request FSM with its latched request, latency counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            cnt_r   <= CNT_W'(0);
            idx_r   <= AW'(0);
            wdata_r <= 256'd0;
            write_r <= 1'b0;
            ack_r   <= 1'b0;
            data_r  <= 256'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r <= 1'b0;
                    if (enable_i) begin
                        idx_r   <= addr_i[IDX_LSB +: AW];
                        wdata_r <= data_i;
                        write_r <= write_i;
                        cnt_r   <= CNT_LOAD;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_W'(0)) begin
                        ack_r   <= 1'b1;
                        state_r <= ACK;
                        if (!write_r) begin
                            data_r <= rd_line_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ACK: begin
                    ack_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ack_r   <= 1'b0;
                    cnt_r   <= CNT_W'(0);
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
